// File: rtl/mini16_btn_pkg.sv
// Shared definitions for the mini16 push-button input path: debounce FSM
// encoding and default timing constants for a 50 MHz system clock.
package mini16_btn_pkg;

  typedef enum logic [1:0] {
    BTN_UP       = 2'd0,
    BTN_ARM_DOWN = 2'd1,
    BTN_DOWN     = 2'd2,
    BTN_ARM_UP   = 2'd3
  } btn_state_t;

  // 10 ms at 50 MHz
  localparam int BTN_DEBOUNCE_50MHZ = 500000;
  localparam int BTN_CNT_WIDTH      = 20;

endpackage

// File: rtl/mini16_debounce_ch.sv
// One key channel: two-flop synchronizer, debounce FSM with counter, and
// registered one-cycle press/release pulses.
module mini16_debounce_ch
  import mini16_btn_pkg::*;
#(
  parameter int DEBOUNCE_COUNT = BTN_DEBOUNCE_50MHZ,
  parameter int CNT_WIDTH      = BTN_CNT_WIDTH
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_n,
  output logic       level,
  output logic       press,
  output logic       release_pulse,
  output btn_state_t state_dbg
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [1:0]           sync_q;
  logic                 s;
  btn_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 press_d, release_d;

  // Synchronizer resets to "released" so reset never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], btn_n};
  end

  assign s = ~sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= BTN_UP;
      cnt_q         <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      press         <= press_d;
      release_pulse <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      BTN_UP: begin
        if (s) begin
          state_d = BTN_ARM_DOWN;
          cnt_d   = CNT_ONE;
        end
      end
      BTN_ARM_DOWN: begin
        if (!s) begin
          state_d = BTN_UP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = BTN_DOWN;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      BTN_DOWN: begin
        if (!s) begin
          state_d = BTN_ARM_UP;
          cnt_d   = CNT_ONE;
        end
      end
      BTN_ARM_UP: begin
        if (s) begin
          state_d = BTN_DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = BTN_UP;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = BTN_UP;
        cnt_d   = '0;
      end
    endcase
  end

  assign level     = (state_q == BTN_DOWN) || (state_q == BTN_ARM_UP);
  assign state_dbg = state_q;

endmodule

// File: rtl/mini16_button_in.sv
// Push-button conditioner: WIDTH independent debounce channels plus an
// optional sticky press-event register built when MINI16_BTN_EVENT_LATCH_EN is defined.
// Handshake: none; press/release are single-cycle strobes, evt_clr is a
// per-bit level sampled every clock, and a set beats a clear in the same cycle.
module mini16_button_in
  import mini16_btn_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int DEBOUNCE_COUNT = BTN_DEBOUNCE_50MHZ,
  parameter int CNT_WIDTH      = BTN_CNT_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   btn_n,
  input  logic [WIDTH-1:0]   evt_clr,
  output logic [WIDTH-1:0]   level,
  output logic [WIDTH-1:0]   press,
  // "release" is a reserved word, hence the suffix
  output logic [WIDTH-1:0]   release_pulse,
  output logic [WIDTH-1:0]   evt,
  output logic [2*WIDTH-1:0] state_dbg
);

  btn_state_t ch_state [WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    mini16_debounce_ch #(
      .DEBOUNCE_COUNT (DEBOUNCE_COUNT),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_ch (
      .clk           (clk),
      .reset_n       (reset_n),
      .btn_n         (btn_n[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .state_dbg     (ch_state[i])
    );
    assign state_dbg[2*i +: 2] = ch_state[i];
  end

`ifdef MINI16_BTN_EVENT_LATCH_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) evt <= '0;
    else          evt <= press | (evt & ~evt_clr);
  end
`else
  logic unused_evt_clr;
  assign unused_evt_clr = ^evt_clr;
  assign evt            = '0;
`endif

endmodule

// File: tb/tb_mini16_button_in.sv
// Bench for mini16_button_in with DEBOUNCE_COUNT=8: directed scenarios plus
// randomized key traffic, checked against a run-length reference model.
module tb_mini16_button_in;

  localparam int W  = 4;
  localparam int DC = 8;
  localparam int CW = 4;
  localparam int QW = 23;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [W-1:0]   btn_n = '0;
  logic [W-1:0]   evt_clr = '0;
  logic [W-1:0]   level, press, release_pulse, evt;
  logic [2*W-1:0] state_dbg;

  always #5 clk = ~clk;

  mini16_button_in #(
    .WIDTH          (W),
    .DEBOUNCE_COUNT (DC),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .btn_n         (btn_n),
    .evt_clr       (evt_clr),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .evt           (evt),
    .state_dbg     (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [QW-1:0] exp_q[$];

  // Reference model: raw keys pass through a 2-cycle delay; a key commits
  // once its delayed value has disagreed with the level for DC edges in a row.
  logic [W-1:0] m_sa, m_sb, m_s, m_level, m_press, m_rel, m_evt;
  int m_run [W];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_sa = '1; m_sb = '1; m_level = '0; m_press = '0; m_rel = '0; m_evt = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
`ifdef MINI16_BTN_EVENT_LATCH_EN
      m_evt = m_press | (m_evt & ~evt_clr);
`else
      m_evt = '0;
`endif
      m_s = ~m_sb;
      m_press = '0;
      m_rel = '0;
      for (int i = 0; i < W; i++) begin
        if (m_s[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == DC) begin
            m_run[i] = 0;
            m_level[i] = m_s[i];
            if (m_s[i]) m_press[i] = 1'b1;
            else        m_rel[i] = 1'b1;
            exp_q.push_back({cyc[19:0], ~m_s[i], 2'(i)});
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_sb = m_sa;
      m_sa = btn_n;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_pulse(input int ch, input logic kind);
    logic [QW-1:0] got;
    logic [QW-1:0] want;
    checks++;
    want = {cyc[19:0], kind, 2'(ch)};
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_pulse: ch %0d kind %0d at cycle %0d, none expected", ch, kind, cyc);
    end else begin
      got = exp_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL pulse_order: dut ch %0d kind %0d cycle %0d, expected ch %0d kind %0d cycle %0d",
                 ch, kind, cyc, got[1:0], got[2], got[22:3]);
      end
    end
  endtask

  // Monitor: consumes expected pulses and compares level/evt every cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0][22:3] < cyc[19:0]) begin
      checks++;
      errors++;
      $display("FAIL missed_pulse: ch %0d kind %0d due cycle %0d, not seen by cycle %0d",
               exp_q[0][1:0], exp_q[0][2], exp_q[0][22:3], cyc);
      void'(exp_q.pop_front());
    end
    for (int i = 0; i < W; i++) begin
      if (press[i] && release_pulse[i]) begin
        checks++;
        errors++;
        $display("FAIL both_pulses: ch %0d press=1 release=1 required not both", i);
      end
      if (press[i])         check_pulse(i, 1'b0);
      if (release_pulse[i]) check_pulse(i, 1'b1);
    end
    chk("level", level, m_level);
    chk("evt", evt, m_evt);
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_press(input int ch);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (press[ch]) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL press_timeout: ch %0d got no press within 20 cycles, required one", ch);
    end
  endtask

  int hold [W];

  initial begin
    // Reset with every key held down
    btn_n = 4'b0000;
    reset_n = 1'b0;
    tick(3);
    chk("reset_level", level, '0);
    chk("reset_press", press, '0);
    chk("reset_release", release_pulse, '0);
    chk("reset_evt", evt, '0);
    reset_n = 1'b1;
    tick(12);
    chk("held_through_reset_level", level, 4'b1111);
    btn_n = '1;
    tick(12);

    // Clean press/release on key0
    btn_n[0] = 1'b0;
    tick(30);
    btn_n[0] = 1'b1;
    tick(14);

    // Bouncing key1, then held
    for (int i = 0; i < 8; i++) begin
      btn_n[1] = ~btn_n[1];
      tick(3);
    end
    btn_n[1] = 1'b0;
    tick(14);
    chk("bounce_level", level & 4'b0010, 4'b0010);
    btn_n[1] = 1'b1;
    tick(14);

    // Seven-cycle glitch on key2
    btn_n[2] = 1'b0;
    tick(7);
    btn_n[2] = 1'b1;
    tick(12);
    chk("glitch_level", level & 4'b0100, 4'b0000);

    // Event register on key3: set, set-beats-clear, isolated clear
    btn_n[3] = 1'b0;
    wait_press(3);
    tick(1);
`ifdef MINI16_BTN_EVENT_LATCH_EN
    chk("evt_set", evt & 4'b1000, 4'b1000);
`else
    chk("evt_tied", evt, 4'b0000);
`endif
    btn_n[3] = 1'b1;
    tick(14);
    btn_n[3] = 1'b0;
    wait_press(3);
    evt_clr[3] = 1'b1;
    tick(1);
    evt_clr[3] = 1'b0;
`ifdef MINI16_BTN_EVENT_LATCH_EN
    chk("evt_set_wins", evt & 4'b1000, 4'b1000);
`endif
    tick(4);
    evt_clr[3] = 1'b1;
    tick(1);
    evt_clr[3] = 1'b0;
    chk("evt_cleared", evt & 4'b1000, 4'b0000);
    btn_n[3] = 1'b1;
    tick(14);

    // Async reset while key0 is mid-debounce and key1 is committed
    btn_n[1] = 1'b0;
    tick(12);
    btn_n[0] = 1'b0;
    tick(7);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_level", level, '0);
    chk("async_reset_press", press, '0);
    chk("async_reset_evt", evt, '0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(14);
    btn_n = '1;
    tick(14);

    // Randomized key traffic with sparse clears and occasional resets
    for (int i = 0; i < W; i++) hold[i] = $urandom_range(1, 14);
    repeat (1500) begin
      for (int i = 0; i < W; i++) begin
        if (hold[i] == 0) begin
          btn_n[i] = ~btn_n[i];
          hold[i] = $urandom_range(1, 14);
        end else begin
          hold[i]--;
        end
      end
      evt_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : '0;
      if ($urandom_range(0, 300) == 0) begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end else begin
        tick(1);
      end
    end
    btn_n = '1;
    evt_clr = '0;
    tick(20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: %0d pulses still queued, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
